// File: rtl/en_reset_pipe_reg.sv
// en_reset_pipe_reg: p_nstages-deep enable/reset delay line with per-stage
// valid bits, synchronous flush (clear) and a registered occupancy count.
// Priority per edge: reset > clear > en > hold.
// Optional macro EN_RESET_PIPE_ASSERT_EN compiles in simulation-only checks
// (known control inputs, count == popcount of valid bits); without it the
// checks are absent and behaviour is identical.
module en_reset_pipe_reg #(
  parameter int                 p_nbits       = 1,
  parameter int                 p_nstages     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             clear,
  input  logic                             in_val,
  input  logic [p_nbits-1:0]               in_data,
  output logic                             out_val,
  output logic [p_nbits-1:0]               out_data,
  output logic [$clog2(p_nstages+1)-1:0]   count
);

  localparam int c_cw = $clog2(p_nstages + 1);

  logic [p_nbits-1:0] r_data [p_nstages];
  logic [p_nstages-1:0] r_val;
  logic [c_cw-1:0]      r_count;
  logic [c_cw-1:0]      w_count_next;

  // Stage 0: captures the incoming item (data is taken even when in_val=0)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data[0] <= p_reset_value;
      r_val[0]  <= 1'b0;
    end else if (clear) begin
      r_val[0]  <= 1'b0;
    end else if (en) begin
      r_data[0] <= in_data;
      r_val[0]  <= in_val;
    end
  end

  // Stages 1..N-1: shift from the previous stage on enable; empty when N=1
  generate
    for (genvar gi = 1; gi < p_nstages; gi++) begin : g_stage
      // Shift one stage forward; clear drops valid but keeps the data word
      always_ff @(posedge clk) begin
        if (reset) begin
          r_data[gi] <= p_reset_value;
          r_val[gi]  <= 1'b0;
        end else if (clear) begin
          r_val[gi]  <= 1'b0;
        end else if (en) begin
          r_data[gi] <= r_data[gi-1];
          r_val[gi]  <= r_val[gi-1];
        end
      end
    end
  endgenerate

  // Occupancy update: one item may enter and one may leave per enabled edge.
  // When the pipe is full the last stage is valid, so the sum never exceeds N.
  always_comb begin
    w_count_next = r_count + c_cw'(in_val) - c_cw'(r_val[p_nstages-1]);
  end

  // Registered occupancy counter tracking popcount of the valid bits
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_count_next;
    end
  end

  assign out_val  = r_val[p_nstages-1];
  assign out_data = r_data[p_nstages-1];
  assign count    = r_count;

`ifdef EN_RESET_PIPE_ASSERT_EN
  // Simulation-only consistency checks while out of reset
  always @(posedge clk) begin
    if (!reset) begin
      assert (!$isunknown({en, clear, in_val}))
        else $error("en_reset_pipe_reg: X/Z on en, clear or in_val");
      assert (r_count == c_cw'($countones(r_val)))
        else $error("en_reset_pipe_reg: count %0d != popcount(val) %0d",
                    r_count, $countones(r_val));
    end
  end
`endif

endmodule

// File: tb/tb_en_reset_pipe_reg.sv
// Self-checking bench for en_reset_pipe_reg (N=3, 8-bit, reset value 8'hA5).
// A scoreboard queue holds the expected contents of stages 0..N-2; every
// enabled edge pushes the driven item and pops the one due at the output.
module tb_en_reset_pipe_reg;

  localparam int          c_nbits   = 8;
  localparam int          c_nstages = 3;
  localparam logic [7:0]  c_rv      = 8'hA5;
  localparam int          c_cw      = $clog2(c_nstages + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              en;
  logic              clear;
  logic              in_val;
  logic [7:0]        in_data;
  logic              out_val;
  logic [7:0]        out_data;
  logic [c_cw-1:0]   count;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } item_t;

  item_t sb_q[$];
  item_t exp_out;
  int    n_checks = 0;
  int    n_errors = 0;

  en_reset_pipe_reg #(
    .p_nbits       (c_nbits),
    .p_nstages     (c_nstages),
    .p_reset_value (c_rv)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (clear),
    .in_val   (in_val),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_data (out_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_count();
    int n = int'(exp_out.v);
    foreach (sb_q[i]) n += int'(sb_q[i].v);
    return n;
  endfunction

  // One clock transaction: drive on negedge, update scoreboard at posedge,
  // compare outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic c, input logic e,
                      input logic v, input logic [7:0] d, input string tag);
    @(negedge clk);
    reset = r; clear = c; en = e; in_val = v; in_data = d;
    @(posedge clk);
    if (r) begin
      sb_q.delete();
      for (int i = 0; i < c_nstages - 1; i++) sb_q.push_back('{1'b0, c_rv});
      exp_out = '{1'b0, c_rv};
    end else if (c) begin
      foreach (sb_q[i]) sb_q[i].v = 1'b0;
      exp_out.v = 1'b0;
    end else if (e) begin
      sb_q.push_back('{v, d});
      exp_out = sb_q.pop_front();
    end
    #1;
    check({tag, "_val"},   32'(out_val),  32'(exp_out.v));
    check({tag, "_data"},  32'(out_data), 32'(exp_out.d));
    check({tag, "_count"}, 32'(count),    32'(exp_count()));
    $display("[%0t] %s rst=%0b clr=%0b en=%0b iv=%0b id=%02h -> ov=%0b od=%02h cnt=%0d",
             $time, tag, r, c, e, v, d, out_val, out_data, count);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; en = 1'b0; in_val = 1'b0; in_data = '0;
    exp_out = '{1'b0, c_rv};

    // 1: reset state
    step(1, 0, 0, 0, 8'h00, "rst");
    check("t1_out_val",  32'(out_val),  32'd0);
    check("t1_out_data", 32'(out_data), 32'hA5);
    check("t1_count",    32'(count),    32'd0);

    // 2: streaming 1..4, latency 3
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 1, 8'(i), "stream");
      if (i == 3) begin
        check("t2_first_out", 32'(out_data), 32'd1);
        check("t2_first_val", 32'(out_val),  32'd1);
      end
    end
    check("t2_count_full", 32'(count),    32'd3);
    check("t2_last_out",   32'(out_data), 32'd2);

    // 3: single item with stalls in between
    step(1, 0, 0, 0, 8'h00, "rst");
    step(0, 0, 1, 1, 8'h11, "push");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'hEE, "stall");
    check("t3_stalled_val", 32'(out_val), 32'd0);
    step(0, 0, 1, 0, 8'h00, "adv");
    check("t3_not_yet", 32'(out_val), 32'd0);
    step(0, 0, 1, 0, 8'h00, "adv");
    check("t3_val",  32'(out_val),  32'd1);
    check("t3_data", 32'(out_data), 32'h11);

    // 4: clear with en/in_val high drops everything including item 9
    for (int i = 5; i <= 7; i++) step(0, 0, 1, 1, 8'(i), "fill");
    step(0, 1, 1, 1, 8'h09, "clear");
    check("t4_count", 32'(count),   32'd0);
    check("t4_val",   32'(out_val), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00, "drain");
    check("t4_no_9", 32'(out_val), 32'd0);

    // 5: alternating valid pattern
    for (int i = 0; i < 8; i++) step(0, 0, 1, 1'(~i[0]), 8'h40 + 8'(i), "alt");

    // 6: reset mid-stream with en=1 does not capture in_data
    step(0, 0, 1, 1, 8'h21, "fly");
    step(0, 0, 1, 1, 8'h22, "fly");
    step(1, 0, 1, 1, 8'h77, "rst_en");
    check("t6_data",  32'(out_data), 32'hA5);
    check("t6_count", 32'(count),    32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h00, "post");
    check("t6_no_77", 32'(out_val), 32'd0);

    // Random mix of enables, valids and occasional clear/reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
